// File: rtl/jtframe_sndrec_pkg.sv
// Shared definitions for the sound-register recorder and player:
// stream token encoding and the player state encoding.
package jtframe_sndrec_pkg;

    localparam logic [7:0] TK_EOF = 8'h00;
    localparam logic [7:0] TK_V5  = 8'h80;
    localparam logic [3:0] TK_WR  = 4'h1;   // upper nibble of a register-write token

    typedef enum logic [2:0] {
        IDLE, RD, DEC, RDD, WR, WV5, DONE
    } snd_st_t;

endpackage

// File: rtl/jtframe_sndplay.sv
// Replays a recorded sound-register byte stream from the record RAM to a
// sound chip port, pacing 80-tokens on rising edges of the 240 Hz v5 signal.
module jtframe_sndplay
    import jtframe_sndrec_pkg::*;
#(
    parameter int AW = 13
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic          v5,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_dout,
    output logic          snd_we,
    output logic [3:0]    snd_a,
    output logic [7:0]    snd_dout,
    input  logic          snd_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    snd_st_t       st, st_nx;
    logic [AW-1:0] addr_nx;
    logic [3:0]    a_nx;
    logic [7:0]    dout_nx;
    logic          we_nx, err_nx;
    logic          v5l;
    // RDD spans two cycles: address settle, then data latch
    logic          rdd_lat, lat_nx;
    // data byte sat at the top address: finish (or loop) once it is written
    logic          eof_pend, eof_nx;
    logic          last;

    assign last = &ram_addr;
    assign busy = (st != IDLE) && (st != DONE);
    assign done = (st == DONE);

    always_comb begin
        st_nx   = st;
        addr_nx = ram_addr;
        a_nx    = snd_a;
        dout_nx = snd_dout;
        we_nx   = snd_we;
        err_nx  = err;
        lat_nx  = 1'b0;
        eof_nx  = eof_pend;
        unique case (st)
            IDLE, DONE: if (start) begin
                addr_nx = '0;
                err_nx  = 1'b0;
                eof_nx  = 1'b0;
                st_nx   = RD;
            end
            RD: st_nx = DEC;
            DEC: begin
                if (ram_dout == TK_EOF) begin
                    if (loop) begin
                        addr_nx = '0;
                        st_nx   = RD;
                    end else begin
                        st_nx = DONE;
                    end
                end else if (ram_dout == TK_V5) begin
                    // advancing past the top is an implicit EOF
                    if (!last) begin
                        addr_nx = ram_addr + 1'b1;
                        st_nx   = WV5;
                    end else if (loop) begin
                        addr_nx = '0;
                        st_nx   = RD;
                    end else begin
                        st_nx = DONE;
                    end
                end else if (ram_dout[7:4] == TK_WR) begin
                    if (last) begin
                        err_nx = 1'b1;
                        st_nx  = DONE;
                    end else begin
                        a_nx    = ram_dout[3:0];
                        addr_nx = ram_addr + 1'b1;
                        st_nx   = RDD;
                    end
                end else begin
                    err_nx = 1'b1;
                    st_nx  = DONE;
                end
            end
            RDD: begin
                if (!rdd_lat) begin
                    lat_nx = 1'b1;
                end else begin
                    dout_nx = ram_dout;
                    we_nx   = 1'b1;
                    st_nx   = WR;
                    if (last) eof_nx  = 1'b1;
                    else      addr_nx = ram_addr + 1'b1;
                end
            end
            WR: if (snd_ready) begin
                we_nx = 1'b0;
                if (eof_pend) begin
                    eof_nx = 1'b0;
                    if (loop) begin
                        addr_nx = '0;
                        st_nx   = RD;
                    end else begin
                        st_nx = DONE;
                    end
                end else begin
                    st_nx = RD;
                end
            end
            WV5: if (v5 && !v5l) st_nx = RD;
            default: st_nx = IDLE;
        endcase
        // stop overrides everything, including a simultaneous start
        if (stop) begin
            st_nx  = IDLE;
            we_nx  = 1'b0;
            lat_nx = 1'b0;
            eof_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            ram_addr <= '0;
            snd_we   <= 1'b0;
            snd_a    <= 4'd0;
            snd_dout <= 8'd0;
            err      <= 1'b0;
            v5l      <= 1'b0;
            rdd_lat  <= 1'b0;
            eof_pend <= 1'b0;
        end else begin
            st       <= st_nx;
            ram_addr <= addr_nx;
            snd_we   <= we_nx;
            snd_a    <= a_nx;
            snd_dout <= dout_nx;
            err      <= err_nx;
            v5l      <= v5;
            rdd_lat  <= lat_nx;
            eof_pend <= eof_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_sndplay.sv
// Self-checking bench for jtframe_sndplay: directed timing cases plus random
// streams scored against a token-level model of the playback rules.
module tb_jtframe_sndplay;

    localparam int AW  = 6;
    localparam int TOP = (1 << AW) - 1;

    logic          rst, clk, start, stop, loop, v5, snd_ready;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;
    logic          snd_we, busy, done, err;
    logic [3:0]    snd_a;
    logic [7:0]    snd_dout;

    jtframe_sndplay #(.AW(AW)) dut (
        .rst(rst), .clk(clk), .start(start), .stop(stop), .loop(loop), .v5(v5),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .snd_we(snd_we), .snd_a(snd_a),
        .snd_dout(snd_dout), .snd_ready(snd_ready), .busy(busy), .done(done), .err(err)
    );

    logic [7:0]  mem [TOP+1];
    logic [11:0] acc_q[$], exp_q[$];
    int          acc_cyc[$];
    logic        exp_err;
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, last_acc = 0, min_gap = 1000;
    logic        have_last = 0, seen_nz = 0, reread = 0;
    logic        v5_auto = 0, v5_man = 0, rdy_auto = 0, rdy_man = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    // record RAM read port: data one clock after the address
    always @(posedge clk) ram_dout <= mem[ram_addr];

    // paced inputs: either random or following the manual level
    initial begin
        v5 = 0; snd_ready = 0;
        forever begin
            @(posedge clk); #2;
            v5        = v5_auto  ? (($urandom_range(0, 7) == 0) ? ~v5 : v5) : v5_man;
            snd_ready = rdy_auto ? ($urandom_range(0, 3) != 0) : rdy_man;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (snd_we && snd_ready) begin
            acc_q.push_back({snd_a, snd_dout});
            acc_cyc.push_back(cyc);
            if (have_last && (cyc - last_acc) < min_gap) min_gap <= cyc - last_acc;
            last_acc  <= cyc;
            have_last <= 1'b1;
        end
        if (busy && ram_addr != 0) seen_nz <= 1'b1;
        if (busy && seen_nz && ram_addr == 0) reread <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i <= TOP; i++) mem[i] = 8'h00;
        acc_q.delete(); acc_cyc.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin tick(); k++; end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
    endtask

    // token-level reading of the stream: which writes happen and whether it errs
    task automatic model();
        int p = 0;
        logic [7:0] t;
        exp_q.delete(); exp_err = 0;
        while (1) begin
            t = mem[p];
            if (t == 8'h00) break;
            else if (t == 8'h80) begin
                if (p == TOP) break;
                p++;
            end else if (t[7:4] == 4'h1) begin
                if (p == TOP) begin exp_err = 1; break; end
                exp_q.push_back({t[3:0], mem[p+1]});
                if (p + 1 == TOP) break;
                p += 2;
            end else begin
                exp_err = 1; break;
            end
        end
    endtask

    task automatic score(input string tag);
        chk({tag, " nwr"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk({tag, " wr"}, {20'd0, acc_q[i]}, {20'd0, exp_q[i]});
        chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        logic ok;
        int   n, nb;
        rst = 1; start = 0; stop = 0; loop = 0;
        clear_mem();
        tick(3);
        chk("reset outs", {ram_addr, snd_we, snd_a, snd_dout, busy, done, err}, 0);
        rst = 0;
        tick(2);
        chk("idle outs", {ram_addr, snd_we, snd_a, snd_dout, busy, done, err}, 0);

        // single write, exact latency
        mem[0] = 8'h12; mem[1] = 8'h34; rdy_man = 1;
        pulse_start();
        chk("t1 busy", {31'd0, busy}, 1);
        chk("t1 addr0", {26'd0, ram_addr}, 0);
        tick(4);
        chk("t1 wr", {snd_we, snd_a, snd_dout}, {1'b1, 4'h2, 8'h34});
        tick();
        chk("t1 we 1cyc", {31'd0, snd_we}, 0);
        tick();
        chk("t1 done early", {31'd0, done}, 0);
        tick();
        chk("t1 done/busy", {done, busy}, 2'b10);
        chk("t1 nwr", acc_q.size(), 1);

        // v5 pacing; an edge before WV5 must not be remembered
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h13; mem[2] = 8'h55;
        v5_man = 1; start = 1; tick(); start = 0;
        tick(4); v5_man = 0;
        ok = 1;
        repeat (100) begin tick(); if (snd_we) ok = 0; end
        chk("t2 no early we", {31'd0, ok}, 1);
        v5_man = 1;
        n = 0;
        while (!snd_we && n < 10) begin tick(); n++; end
        chk("t2 edge->we", n, 5);
        v5_man = 0;
        wait_done("t2", 50);
        chk("t2 wr", acc_q.size() == 1 ? {20'd0, acc_q[0]} : 32'hdead, 32'h355);

        // stalled write holds stable
        clear_mem();
        mem[0] = 8'h15; mem[1] = 8'hA5; rdy_man = 0;
        pulse_start(); tick(4);
        ok = 1;
        repeat (20) begin
            if (!(snd_we && snd_a == 4'h5 && snd_dout == 8'hA5)) ok = 0;
            tick();
        end
        chk("t3 stable", {31'd0, ok}, 1);
        chk("t3 no accept", acc_q.size(), 0);
        rdy_man = 1; tick(); rdy_man = 0;
        chk("t3 one accept", acc_q.size(), 1);
        chk("t3 we low", {31'd0, snd_we}, 0);
        rdy_man = 1;
        wait_done("t3", 20);

        // looping replay cadence, then stop mid-write
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'hAA; loop = 1;
        pulse_start();
        n = 0;
        while (acc_q.size() < 4 && n < 80) begin tick(); n++; end
        chk("t4 nwr", acc_q.size(), 4);
        for (int i = 0; i < 3 && i + 1 < acc_cyc.size(); i++)
            chk("t4 period", acc_cyc[i+1] - acc_cyc[i], 7);
        chk("t4 wr", {20'd0, acc_q[0]}, 32'h1AA);
        n = 0;
        while (!snd_we && n < 10) begin tick(); n++; end
        nb = acc_q.size();
        stop = 1; tick(); stop = 0;
        chk("t4 stop outs", {snd_we, busy, done}, 3'b000);
        chk("t4 stop accept", acc_q.size(), nb + 1);
        tick(10);
        chk("t4 quiet", acc_q.size(), nb + 1);
        loop = 0;

        // bad token, then a clean start clears err
        clear_mem();
        mem[0] = 8'h42;
        pulse_start();
        wait_done("t5", 20);
        chk("t5 err", {31'd0, err}, 1);
        chk("t5 nwr", acc_q.size(), 0);
        mem[0] = 8'h00;
        pulse_start();
        chk("t5 err clr", {31'd0, err}, 0);
        wait_done("t5b", 20);

        // pairs running to the top address: wrap is EOF
        clear_mem();
        for (int i = 0; i <= TOP; i += 2) begin
            mem[i] = 8'h10 | 8'(i & 15); mem[i+1] = 8'($urandom);
        end
        model();
        seen_nz = 0; reread = 0;
        pulse_start();
        wait_done("t6", 600);
        score("t6");
        chk("t6 no reread", {31'd0, reread}, 0);
        chk("t6 addr top", {26'd0, ram_addr}, TOP);

        // register token at the top address has no data byte
        clear_mem();
        mem[0] = 8'h80;
        for (int i = 1; i < TOP; i += 2) begin
            mem[i] = 8'h1C; mem[i+1] = 8'(i);
        end
        mem[TOP] = 8'h17;
        model();
        v5_auto = 1;
        pulse_start();
        wait_done("t6b", 800);
        score("t6b");

        // random streams with random ready/v5
        rdy_auto = 1;
        for (int it = 0; it < 20; it++) begin
            int p = 0;
            int r;
            clear_mem();
            while (p <= TOP) begin
                r = $urandom_range(0, 99);
                if (r < 72) begin
                    mem[p] = 8'h10 | 8'($urandom_range(0, 15));
                    if (p < TOP) mem[p+1] = 8'($urandom);
                    p += 2;
                end else if (r < 88) begin
                    mem[p] = 8'h80; p++;
                end else if (r < 91) begin
                    mem[p] = 8'($urandom_range(8'h20, 8'h7F)); p++;
                end else if (r < 96) begin
                    mem[p] = 8'h00; break;
                end else p++;
            end
            model();
            pulse_start();
            wait_done("rnd", 3000);
            score("rnd");
        end
        rdy_auto = 0; v5_auto = 0;
        chk("min wr gap", {31'd0, min_gap >= 5}, 1);

        // asynchronous reset mid-operation
        clear_mem();
        mem[0] = 8'h11; mem[1] = 8'hAA; loop = 1; rdy_man = 1;
        pulse_start(); tick(3);
        #3 rst = 1;
        #1 chk("async rst", {ram_addr, snd_we, snd_a, snd_dout, busy, done, err}, 0);
        tick(); rst = 0; loop = 0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
